vm1_vcram_ctl: RTL and testbench

Front-end controller for the 1801VM1 64-word dual-port register RAM; it sits directly upstream of the RAM wrapper and drives both of its ports. After reset it clears all 64 words with a hardware sweep. In run mode it passes core read/write requests through to the RAM, resolves same-address write collisions between the two ports, and returns read data with a valid strobe. Read-after-write forwarding is an optional build feature.

---
 rtl/vm1_vcram_pkg.sv | 24 ++
 rtl/vm1_vcram_fwd.sv | 60 ++++++
 rtl/vm1_vcram_ctl.sv | 144 ++++++++++++++
 tb/tb_vm1_vcram_ctl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm1_vcram_pkg.sv
// vm1_vcram_pkg: constants, state encoding and byte-merge helper shared by the
// 1801VM1 register-RAM front-end controller and its forwarding sub-module.
package vm1_vcram_pkg;

  localparam int VCRAM_AW    = 6;
  localparam int VCRAM_DW    = 16;
  localparam int VCRAM_DEPTH = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } vcram_state_e;

  // Per-byte select: bytes of upd whose enable bit is set replace bytes of base.
  function automatic logic [VCRAM_DW-1:0] byte_merge(
    input logic [VCRAM_DW-1:0] base,
    input logic [VCRAM_DW-1:0] upd,
    input logic [1:0]          be
  );
    byte_merge = {be[1] ? upd[15:8] : base[15:8],
                  be[0] ? upd[7:0]  : base[7:0]};
  endfunction

endpackage

// File: rtl/vm1_vcram_fwd.sv
// vm1_vcram_fwd: read-after-write forwarding for one read port of the VCRAM.
// Captures the read address and both RAM write ports in the request cycle,
// then patches the (read-first) RAM output with those same-cycle writes.
// Port A bytes override port B bytes.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   rd_addr_i           address presented to this RAM port this cycle
//   wa_en_i/addr/be/data  committed write on RAM port A this cycle
//   wb_en_i/addr/data     committed write on RAM port B this cycle (full word)
//   q_i                 RAM read data (one cycle after rd_addr_i)
//   rdata_o             write-first read data
module vm1_vcram_fwd
  import vm1_vcram_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [VCRAM_AW-1:0] rd_addr_i,
  input  logic                wa_en_i,
  input  logic [VCRAM_AW-1:0] wa_addr_i,
  input  logic [1:0]          wa_be_i,
  input  logic [VCRAM_DW-1:0] wa_data_i,
  input  logic                wb_en_i,
  input  logic [VCRAM_AW-1:0] wb_addr_i,
  input  logic [VCRAM_DW-1:0] wb_data_i,
  input  logic [VCRAM_DW-1:0] q_i,
  output logic [VCRAM_DW-1:0] rdata_o
);

  logic [VCRAM_AW-1:0] rd_addr_q;
  logic                wa_en_q, wb_en_q;
  logic [VCRAM_AW-1:0] wa_addr_q, wb_addr_q;
  logic [1:0]          wa_be_q;
  logic [VCRAM_DW-1:0] wa_data_q, wb_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wa_en_q <= 1'b0;
      wb_en_q <= 1'b0;
    end else begin
      wa_en_q <= wa_en_i;
      wb_en_q <= wb_en_i;
    end
    rd_addr_q <= rd_addr_i;
    wa_addr_q <= wa_addr_i;
    wa_be_q   <= wa_be_i;
    wa_data_q <= wa_data_i;
    wb_addr_q <= wb_addr_i;
    wb_data_q <= wb_data_i;
  end

  // B applied first so that A wins on any shared byte lane.
  always_comb begin
    rdata_o = q_i;
    if (wb_en_q && (wb_addr_q == rd_addr_q))
      rdata_o = byte_merge(rdata_o, wb_data_q, 2'b11);
    if (wa_en_q && (wa_addr_q == rd_addr_q))
      rdata_o = byte_merge(rdata_o, wa_data_q, wa_be_q);
  end

endmodule

// File: rtl/vm1_vcram_ctl.sv
// vm1_vcram_ctl: front-end controller for the 1801VM1 64x16 dual-port
// register RAM. Clears the RAM with a 64-cycle sweep after reset, then passes
// core requests through, resolves same-address write collisions (port A wins
// per byte) and returns read data with a one-cycle valid strobe.
// Build option: define VM1_VCRAM_BYPASS_EN for write-first read forwarding.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   ready                              sweep done, requests accepted
//   a_addr/a_be/a_wr/a_rd/a_wdata      port A request (byte-enabled writes)
//   a_rdata/a_rvalid                   port A read return
//   b_addr/b_wr/b_rd/b_wdata           port B request (full-word writes)
//   b_rdata/b_rvalid                   port B read return
//   ram_*                              RAM wrapper interface
module vm1_vcram_ctl
  import vm1_vcram_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  output logic                ready,
  input  logic [VCRAM_AW-1:0] a_addr,
  input  logic [1:0]          a_be,
  input  logic                a_wr,
  input  logic                a_rd,
  input  logic [VCRAM_DW-1:0] a_wdata,
  output logic [VCRAM_DW-1:0] a_rdata,
  output logic                a_rvalid,
  input  logic [VCRAM_AW-1:0] b_addr,
  input  logic                b_wr,
  input  logic                b_rd,
  input  logic [VCRAM_DW-1:0] b_wdata,
  output logic [VCRAM_DW-1:0] b_rdata,
  output logic                b_rvalid,
  output logic [VCRAM_AW-1:0] ram_address_a,
  output logic [VCRAM_AW-1:0] ram_address_b,
  output logic [1:0]          ram_byteena_a,
  output logic [VCRAM_DW-1:0] ram_data_a,
  output logic [VCRAM_DW-1:0] ram_data_b,
  output logic                ram_wren_a,
  output logic                ram_wren_b,
  input  logic [VCRAM_DW-1:0] ram_q_a,
  input  logic [VCRAM_DW-1:0] ram_q_b
);

  vcram_state_e        state_q, state_d;
  logic [VCRAM_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic                a_rvalid_q, b_rvalid_q;
  logic                collide;

  assign collide = a_wr & b_wr & (a_addr == b_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == VCRAM_AW'(VCRAM_DEPTH - 1))
        state_d = ST_RUN;
    end
  end

  always_comb begin
    ready         = (state_q == ST_RUN);
    ram_address_a = a_addr;
    ram_address_b = b_addr;
    ram_byteena_a = a_be;
    ram_data_a    = a_wdata;
    ram_data_b    = b_wdata;
    ram_wren_a    = a_wr;
    ram_wren_b    = b_wr;
    if (state_q == ST_INIT) begin
      ram_address_a = clr_cnt_q;
      ram_wren_a    = 1'b1;
      ram_byteena_a = 2'b11;
      ram_data_a    = '0;
      ram_address_b = '0;
      ram_data_b    = '0;
      ram_wren_b    = 1'b0;
    end else if (collide) begin
      // Fold B's word into A's write so one full-word write lands.
      ram_wren_b    = 1'b0;
      ram_byteena_a = 2'b11;
      ram_data_a    = byte_merge(b_wdata, a_wdata, a_be);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rd & ready;
      b_rvalid_q <= b_rd & ready;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

`ifdef VM1_VCRAM_BYPASS_EN
  vm1_vcram_fwd u_fwd_a (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_i (ram_address_a),
    .wa_en_i   (ram_wren_a),
    .wa_addr_i (ram_address_a),
    .wa_be_i   (ram_byteena_a),
    .wa_data_i (ram_data_a),
    .wb_en_i   (ram_wren_b),
    .wb_addr_i (ram_address_b),
    .wb_data_i (ram_data_b),
    .q_i       (ram_q_a),
    .rdata_o   (a_rdata)
  );

  vm1_vcram_fwd u_fwd_b (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_i (ram_address_b),
    .wa_en_i   (ram_wren_a),
    .wa_addr_i (ram_address_a),
    .wa_be_i   (ram_byteena_a),
    .wa_data_i (ram_data_a),
    .wb_en_i   (ram_wren_b),
    .wb_addr_i (ram_address_b),
    .wb_data_i (ram_data_b),
    .q_i       (ram_q_b),
    .rdata_o   (b_rdata)
  );
`else
  assign a_rdata = ram_q_a;
  assign b_rdata = ram_q_b;
`endif

endmodule

// File: tb/tb_vm1_vcram_ctl.sv
module tb_vm1_vcram_ctl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic [5:0]  a_addr = '0;
  logic [1:0]  a_be = '0;
  logic        a_wr = 1'b0, a_rd = 1'b0;
  logic [15:0] a_wdata = '0;
  logic [15:0] a_rdata;
  logic        a_rvalid;
  logic [5:0]  b_addr = '0;
  logic        b_wr = 1'b0, b_rd = 1'b0;
  logic [15:0] b_wdata = '0;
  logic [15:0] b_rdata;
  logic        b_rvalid;
  logic [5:0]  ram_address_a, ram_address_b;
  logic [1:0]  ram_byteena_a;
  logic [15:0] ram_data_a, ram_data_b;
  logic        ram_wren_a, ram_wren_b;
  logic [15:0] ram_q_a, ram_q_b;

  int n_cmp = 0;
  int n_err = 0;

  // Write-first expected data only in the forwarding build.
`ifdef VM1_VCRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clock = ~clock;

  vm1_vcram_ctl dut (
    .clock(clock), .reset(reset), .ready(ready),
    .a_addr(a_addr), .a_be(a_be), .a_wr(a_wr), .a_rd(a_rd), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_addr(b_addr), .b_wr(b_wr), .b_rd(b_rd), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
    .ram_byteena_a(ram_byteena_a), .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // Dual-port RAM: registered read-first outputs, byte-enabled port A.
  logic [15:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
  always @(posedge clock) begin
    ram_q_a <= mem[ram_address_a];
    ram_q_b <= mem[ram_address_b];
    if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
    if (ram_wren_a) begin
      if (ram_byteena_a[0]) mem[ram_address_a][7:0]  <= ram_data_a[7:0];
      if (ram_byteena_a[1]) mem[ram_address_a][15:8] <= ram_data_a[15:8];
    end
  end

  // Reference model: the word contents the core should see.
  logic [15:0] shadow [64];
  logic        exp_av, exp_bv;
  logic [15:0] exp_ad, exp_bd;
  logic        snap_wren_b;
  logic [1:0]  snap_be_a;
  logic [15:0] snap_data_a;

  function automatic logic [15:0] bmerge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] be);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 2; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One RUN-mode cycle, entered and left at posedge+1.
  task automatic step(input logic awr, input logic ard, input logic [5:0] aad,
                      input logic [1:0] abe, input logic [15:0] awd,
                      input logic bwr, input logic brd, input logic [5:0] bad,
                      input logic [15:0] bwd);
    logic [15:0] old_a, old_b;
    a_wr = awr; a_rd = ard; a_addr = aad; a_be = abe; a_wdata = awd;
    b_wr = bwr; b_rd = brd; b_addr = bad; b_wdata = bwd;
    #3;
    snap_wren_b = ram_wren_b; snap_be_a = ram_byteena_a; snap_data_a = ram_data_a;
    old_a = shadow[aad];
    old_b = shadow[bad];
    if (bwr) shadow[bad] = bwd;
    if (awr) shadow[aad] = bmerge(shadow[aad], awd, abe);
    exp_av = ard;
    exp_bv = brd;
    exp_ad = BYP ? shadow[aad] : old_a;
    exp_bd = BYP ? shadow[bad] : old_b;
    @(posedge clock); #1;
    a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0;
  endtask

  task automatic test_clear_sweep(input string tag);
    int k;
    k = 0;
    while (!ready && k < 80) begin
      a_wr = 1'($urandom); a_rd = 1'($urandom); b_wr = 1'($urandom); b_rd = 1'($urandom);
      a_addr = 6'($urandom); b_addr = 6'($urandom); a_be = 2'($urandom);
      a_wdata = 16'($urandom) | 16'h1; b_wdata = 16'($urandom) | 16'h1;
      #3;
      n_cmp++;
      if (ram_wren_a !== 1'b1 || ram_address_a !== k[5:0] || ram_data_a !== 16'h0 ||
          ram_byteena_a !== 2'b11 || ram_wren_b !== 1'b0) begin
        n_err++;
        $display("FAIL %s_sweep_write k=%0d got wren_a=%b addr=%0d data=%h be=%b wren_b=%b want 1 %0d 0000 11 0",
                 tag, k, ram_wren_a, ram_address_a, ram_data_a, ram_byteena_a, ram_wren_b, k);
      end
      n_cmp++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL %s_init_rvalid k=%0d got %b%b want 00", tag, k, a_rvalid, b_rvalid);
      end
      @(posedge clock); #1;
      k++;
    end
    a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0;
    n_cmp++;
    if (k != 64) begin
      n_err++;
      $display("FAIL %s_sweep_len got %0d want 64", tag, k);
    end
    n_cmp++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ready_rvalid got %b%b want 00", tag, a_rvalid, b_rvalid);
    end
    for (int i = 0; i < 64; i++) shadow[i] = 16'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    b_wr = 1'b1; b_addr = 6'd7; b_wdata = 16'hFFFF; a_rd = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (ready !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got ready=%b av=%b bv=%b want 0 0 0", ready, a_rvalid, b_rvalid);
    end
    n_cmp++;
    if (ram_address_a !== 6'd0 || ram_wren_a !== 1'b1 || ram_byteena_a !== 2'b11 ||
        ram_data_a !== 16'h0 || ram_wren_b !== 1'b0 || ram_address_b !== 6'd0 ||
        ram_data_b !== 16'h0) begin
      n_err++;
      $display("FAIL reset_ram got a=%0d wa=%b be=%b da=%h wb=%b b=%0d db=%h want 0 1 11 0000 0 0 0000",
               ram_address_a, ram_wren_a, ram_byteena_a, ram_data_a, ram_wren_b,
               ram_address_b, ram_data_b);
    end
    b_wr = 0; a_rd = 0;
    reset = 1'b0;
    test_clear_sweep("reset");
  endtask

  task automatic test_read_all;
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 6'(i), 2'b00, 16'h0, 0, 1, 6'(63 - i), 16'h0);
      n_cmp++;
      if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000) begin
        n_err++;
        $display("FAIL clear_read_a addr=%0d got v=%b d=%h want 1 0000", i, a_rvalid, a_rdata);
      end
      n_cmp++;
      if (b_rvalid !== 1'b1 || b_rdata !== 16'h0000) begin
        n_err++;
        $display("FAIL clear_read_b addr=%0d got v=%b d=%h want 1 0000", 63 - i, b_rvalid, b_rdata);
      end
    end
  endtask

  task automatic test_byte_write;
    step(0, 0, 6'd0, 2'b00, 16'h0, 1, 0, 6'd5, 16'h1234);
    step(1, 0, 6'd5, 2'b01, 16'hABCD, 0, 0, 6'd0, 16'h0);
    step(0, 1, 6'd5, 2'b00, 16'h0, 0, 0, 6'd0, 16'h0);
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h12CD) begin
      n_err++;
      $display("FAIL byte_write got v=%b d=%h want 1 12cd", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_collision;
    step(1, 0, 6'd9, 2'b10, 16'hAA11, 1, 0, 6'd9, 16'h55BB);
    n_cmp++;
    if (snap_wren_b !== 1'b0 || snap_data_a !== 16'hAABB || snap_be_a !== 2'b11) begin
      n_err++;
      $display("FAIL collision_ram got wren_b=%b data_a=%h be_a=%b want 0 aabb 11",
               snap_wren_b, snap_data_a, snap_be_a);
    end
    step(0, 1, 6'd9, 2'b00, 16'h0, 0, 1, 6'd9, 16'h0);
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'hAABB || b_rvalid !== 1'b1 || b_rdata !== 16'hAABB) begin
      n_err++;
      $display("FAIL collision_read got a=%h b=%h want aabb aabb", a_rdata, b_rdata);
    end
  endtask

  task automatic test_forward;
    logic [15:0] want;
    want = BYP ? 16'hCAFE : 16'h0000;
    step(0, 1, 6'd3, 2'b00, 16'h0, 1, 0, 6'd3, 16'hCAFE);
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== want) begin
      n_err++;
      $display("FAIL forward got v=%b d=%h want 1 %h", a_rvalid, a_rdata, want);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 2'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom));
      n_cmp++;
      if (a_rvalid !== exp_av || (exp_av && a_rdata !== exp_ad)) begin
        n_err++;
        $display("FAIL random_a n=%0d got v=%b d=%h want v=%b d=%h", n, a_rvalid, a_rdata, exp_av, exp_ad);
      end
      n_cmp++;
      if (b_rvalid !== exp_bv || (exp_bv && b_rdata !== exp_bd)) begin
        n_err++;
        $display("FAIL random_b n=%0d got v=%b d=%h want v=%b d=%h", n, b_rvalid, b_rdata, exp_bv, exp_bd);
      end
    end
  endtask

  task automatic test_reset_run;
    step(1, 0, 6'd63, 2'b11, 16'hFFFF, 0, 0, 6'd0, 16'h0);
    a_rd = 1'b1; a_addr = 6'd63; reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (a_rvalid !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_run_drop got rvalid=%b ready=%b want 0 0", a_rvalid, ready);
    end
    a_rd = 1'b0; reset = 1'b0;
    test_clear_sweep("rerun");
    step(0, 1, 6'd63, 2'b00, 16'h0, 0, 1, 6'd63, 16'h0);
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_run_read63 got v=%b a=%h b=%h want 1 0000 0000", a_rvalid, a_rdata, b_rdata);
    end
    test_read_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 16'h0;
    @(posedge clock); #1;
    test_reset();
    test_read_all();
    test_byte_write();
    test_collision();
    test_forward();
    test_random();
    test_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
